// File: rtl/gray_rx_tracker_pkg.sv
// Shared defaults and tracker state encoding for the Gray-code receive tracker.
package gray_rx_tracker_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ERR_CNT_W   = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_e;

endpackage

// File: rtl/gray_rx_tracker_gray2bin.sv
// Combinational Gray-to-binary decode; inverse of the upstream binary-to-Gray stage.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_rx_tracker.sv
// Resynchronises an asynchronous Gray bus, decodes it and classifies each
// accepted change as step up, step down or illegal.
module gray_rx_tracker
  import gray_rx_tracker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     g_in,
  output logic [WIDTH-1:0]     b_out,
  output logic                 b_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES:1]              vld_pipe;
  logic [WIDTH-1:0]                  g_s, b_s;
  logic                              primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], g_in};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:1], 1'b1};
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];
  // Hold off the baseline until g_s carries a real sample rather than reset zeros,
  // otherwise the first post-reset compare would flag a bogus jump.
  assign primed = vld_pipe[SYNC_STAGES];

  gray2bin #(.WIDTH(WIDTH)) u_g2b (
    .g (g_s),
    .b (b_s)
  );

  trk_state_e             state, state_nx;
  logic [WIDTH-1:0]       g_prev, g_prev_nx, b_out_nx;
  logic                   b_valid_nx, up_nx, dn_nx, err_nx;
  logic [ERR_CNT_W-1:0]   cnt_nx;
  logic [WIDTH-1:0]       diff, b_inc, b_dec;
  logic                   single_bit;

  assign diff       = g_s ^ g_prev;
  assign single_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign b_inc      = b_out + WIDTH'(1);
  assign b_dec      = b_out - WIDTH'(1);

  always_comb begin
    state_nx   = state;
    g_prev_nx  = g_prev;
    b_out_nx   = b_out;
    b_valid_nx = b_valid;
    cnt_nx     = err_cnt;
    up_nx      = 1'b0;
    dn_nx      = 1'b0;
    err_nx     = 1'b0;
    if (en) begin
      case (state)
        ST_INIT: begin
          if (primed) begin
            g_prev_nx  = g_s;
            b_out_nx   = b_s;
            b_valid_nx = 1'b1;
            state_nx   = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (diff != '0) begin
            // Every change is accepted; illegal ones resync to the new code.
            g_prev_nx = g_s;
            b_out_nx  = b_s;
            if (single_bit && (b_s == b_inc))      up_nx = 1'b1;
            else if (single_bit && (b_s == b_dec)) dn_nx = 1'b1;
            else begin
              err_nx = 1'b1;
              if (!(&err_cnt)) cnt_nx = err_cnt + ERR_CNT_W'(1);
            end
          end
        end
        default: state_nx = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      g_prev  <= '0;
      b_out   <= '0;
      b_valid <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      g_prev  <= g_prev_nx;
      b_out   <= b_out_nx;
      b_valid <= b_valid_nx;
      step_up <= up_nx;
      step_dn <= dn_nx;
      err     <= err_nx;
      err_cnt <= cnt_nx;
    end
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({step_up, step_dn, err}));

  a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
    err_cnt >= $past(err_cnt));

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Scoreboard bench for gray_rx_tracker: stimulus pushes expected events,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_gray_rx_tracker;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int K_UP = 0, K_DN = 1, K_ERR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [W-1:0]  g_in = '0;
  logic [W-1:0]  b_out;
  logic          b_valid, step_up, step_dn, err;
  logic [CW-1:0] err_cnt;

  gray_rx_tracker #(.WIDTH(W), .SYNC_STAGES(S), .ERR_CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .g_in    (g_in),
    .b_out   (b_out),
    .b_valid (b_valid),
    .step_up (step_up),
    .step_dn (step_dn),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int b;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_b    = 0;
  int   m_cnt  = 0;

  function automatic int to_gray(int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: classify a newly accepted binary value against the last one.
  task automatic expect_change(int nb);
    exp_t e;
    if (nb == m_b) return;
    if (nb == ((m_b + 1) & MASK))      e.kind = K_UP;
    else if (nb == ((m_b - 1) & MASK)) e.kind = K_DN;
    else begin
      e.kind = K_ERR;
      if (m_cnt < CMAX) m_cnt++;
    end
    e.b   = nb;
    e.cnt = m_cnt;
    m_b   = nb;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (rst_n && (step_up || step_dn || err)) begin
      kind = step_up ? K_UP : (step_dn ? K_DN : K_ERR);
      chk("pulse_exclusive", 32'(step_up) + 32'(step_dn) + 32'(err), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse kind=%0d b_out=%0d (no event expected)", kind, b_out);
      end else begin
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_b_out", b_out, e.b);
        chk("event_err_cnt", err_cnt, e.cnt);
      end
    end
  end

  task automatic drive_tracked(int nb);
    int old_b;
    old_b = m_b;
    @(posedge clk); #1 g_in = W'(to_gray(nb));
    expect_change(nb);
    repeat (2) @(posedge clk);
    #1 chk("b_out_hold", b_out, old_b);
    @(posedge clk);
    #1 chk("b_out_latency", b_out, m_b);
    @(posedge clk);
  endtask

  task automatic drive_frozen(int nb);
    @(posedge clk); #1 g_in = W'(to_gray(nb));
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset(int gb);
    @(posedge clk); #3;
    g_in  = W'(to_gray(gb));
    rst_n = 1'b0;
    #1;
    chk("rst_b_out", b_out, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_pulses", {step_up, step_dn, err}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sb_empty", sb.size(), 0);
    sb.delete();
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("baseline_not_yet", b_valid, 0);
    @(posedge clk);
    #1;
    chk("baseline_valid", b_valid, 1);
    chk("baseline_b_out", b_out, gb);
    chk("baseline_err_cnt", err_cnt, 0);
    m_b = gb;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int r;
    int wait_cyc;

    // Baseline from Gray 0110 (binary 4)
    do_reset(4);

    // Legal up-count 0,1,2,3 (first move from 4 is an illegal jump)
    drive_tracked(0);
    for (int i = 1; i <= 3; i++) drive_tracked(i);

    // Wrap-around up and back down
    drive_tracked(14);
    drive_tracked(15);
    drive_tracked(0);
    drive_tracked(15);

    // Single-bit non-adjacent jump 1 -> 6
    drive_tracked(1);
    drive_tracked(6);

    // Two-bit jump 0 -> 2
    drive_tracked(0);
    drive_tracked(2);

    // Changes while disabled accumulate into one err on re-enable
    drive_tracked(0);
    @(posedge clk); #1 en = 1'b0;
    drive_frozen(1);
    drive_frozen(2);
    chk("frozen_b_out", b_out, m_b);
    @(posedge clk); #1 en = 1'b1;
    expect_change(2);
    @(posedge clk); #1 chk("reenable_b_out", b_out, 2);
    repeat (3) @(posedge clk);

    // Randomized walk: steps, holds and jumps
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: nb = (m_b + 1) & MASK;
        1: nb = (m_b - 1) & MASK;
        2: nb = m_b;
        default: nb = $urandom_range(0, MASK);
      endcase
      drive_tracked(nb);
    end

    // Saturation: 300 illegal jumps
    for (int i = 0; i < 300; i++) begin
      do nb = $urandom_range(0, MASK);
      while (nb == m_b || nb == ((m_b + 1) & MASK) || nb == ((m_b - 1) & MASK));
      drive_tracked(nb);
    end
    chk("err_cnt_saturated", err_cnt, CMAX);

    // Mid-operation reset, then a few more random moves
    do_reset($urandom_range(0, MASK));
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 2);
      nb = (r == 0) ? ((m_b + 1) & MASK) : (r == 1) ? ((m_b - 1) & MASK) : $urandom_range(0, MASK);
      drive_tracked(nb);
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_rx_tracker.md
Name: gray_rx_tracker

Overview:
Downstream consumer of the 4-bit binary-to-Gray stage. Samples a Gray-coded bus that may change asynchronously to clk and resynchronises it. Decodes it to binary and classifies each change as step up, step down or illegal. Output feeds position/pointer logic that must never see a multi-bit glitch.

Parameters:
WIDTH, 4, width of Gray input and binary output (2..16)
SYNC_STAGES, 2, flip-flop synchroniser depth on g_in (2..4)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  tracking enable; low freezes the tracker and its outputs
g_in  input  WIDTH  Gray-coded input from the binary-to-Gray stage
b_out  output  WIDTH  registered binary value of last accepted code
b_valid  output  1  high once a baseline code has been captured
step_up  output  1  one-cycle pulse: accepted code = previous + 1 (mod 2^WIDTH)
step_dn  output  1  one-cycle pulse: accepted code = previous - 1 (mod 2^WIDTH)
err  output  1  one-cycle pulse: illegal transition detected
err_cnt  output  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, g_prev, b_out, err_cnt = 0; b_valid, step_up, step_dn, err = 0; state = INIT.
- Synchroniser: g_in passes through SYNC_STAGES flops and always runs, independent of en; output g_s.
- Decode: b_s = gray-to-binary(g_s). b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i].
- State INIT: on first cycle with en=1, set g_prev = g_s, b_out = b_s, b_valid = 1, go TRACK. No step or err pulse.
- State TRACK, en=1, compare g_s with g_prev (diff = g_s XOR g_prev):
  - diff = 0: no pulse, hold.
  - Exactly one bit set and b_s = b_out+1 mod 2^WIDTH: step_up=1, update b_out and g_prev.
  - Exactly one bit set and b_s = b_out-1 mod 2^WIDTH: step_dn=1, update.
  - Any other change (multi-bit, or single-bit non-adjacent jump): err=1, err_cnt+1 saturating at all-ones, b_out and g_prev resync to new value.
- Wrap-around: all-ones to 0 is step_up; 0 to all-ones is step_dn. Both are legal single-bit Gray changes.
- en=0: no pulses, b_out, g_prev and state held. On re-enable, the next compare is against the held g_prev, so changes accumulated while disabled may raise err.
- Pulses are registered; at most one of step_up/step_dn/err is high per cycle.
- Latency: g_in change to pulse and new b_out = SYNC_STAGES+1 clk edges (3 at default).
- Reset mid-operation: immediate return to reset values. Tracking re-baselines via INIT; no pulse on the baseline cycle.
- err_cnt is cleared only by reset.

Decomposition:
- Shared package: default WIDTH/SYNC_STAGES/ERR_CNT_W constants and the state enum (INIT, TRACK).
- One natural sub-module, gray2bin (combinational, parameterised WIDTH, XOR chain). It is the inverse of the existing binary-to-Gray stage.
- Synchroniser, compare/classify and state register stay in gray_rx_tracker.

Test Plan:
- Reset with g_in=0110, then release with en=1: after 3 cycles b_out=0100, b_valid=1, no pulses, err_cnt=0.
- Drive Gray sequence 0000, 0001, 0011, 0010 one per 4 cycles: three step_up pulses; b_out ends at 0010 (binary 2), err never asserted.
- Up-count 14, 15, 0 (Gray 1001, 1000, 0000) then down to 15: step_up at 15 and at 0 (wrap), then step_dn at 15; no err.
- From Gray 0001 jump to 0101 (binary 1 to 6): err pulse, err_cnt=1, b_out=0110.
- From 0000 jump to 0011 (two bits): err pulse, b_out=0010.
- Force 300 illegal jumps: err_cnt saturates at 255.
- en=0 while g_in moves 0000 to 0011 via legal steps, then en=1: single err pulse, b_out=0010.
- Assert rst_n low mid-sequence: outputs zero asynchronously. After release, baseline recaptured with no step or err pulse.
